// File: rtl/fan_seg_reduce.sv
// ---------------------------------------------------------------------------
// fan_seg_reduce
//   Pipelined segmented-sum reduction network. Every maximal run of adjacent
//   enabled lanes sharing a row id is summed with a log-depth segmented scan,
//   and the run total is emitted on the last lane of the run.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   block accepts the word this cycle (low only while stalled)
//   in         NUM_IN packed lanes {en, row, data}, lane i at [i*DW_IN +: DW_IN]
//   out_valid  output word valid
//   out_ready  consumer accepts the output word
//   out        NUM_IN packed lanes {vld, row, data}, lane i at [i*DW_OUT +: DW_OUT]
//   seg_total  running count of emitted segments, wraps at 2^16
// ---------------------------------------------------------------------------
module fan_seg_reduce #(
    parameter int NUM_IN   = 32,
    parameter int N_LEVELS = $clog2(NUM_IN),
    parameter int DW_DATA  = 32,
    parameter int DW_ROW   = 4,
    parameter int DW_IN    = DW_DATA + DW_ROW + 1,
    parameter int DW_OUT   = DW_DATA + DW_ROW + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*DW_IN-1:0]  in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_IN*DW_OUT-1:0] out,
    output logic [15:0]              seg_total
);

    localparam int LAST = N_LEVELS;

    // Modulo-2^DW_DATA addition; overflow wraps by design.
    function automatic logic signed [DW_DATA-1:0] add_wrap(
        input logic signed [DW_DATA-1:0] a,
        input logic signed [DW_DATA-1:0] b
    );
        return a + b;
    endfunction

    logic stall;
    logic adv;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;

    // Index 0 is the input register, index k+1 the output of scan level k.
    logic [N_LEVELS:0]         vld_p;
    logic [NUM_IN-1:0]         head_p [N_LEVELS+1];
    logic [NUM_IN-1:0]         tail_p [N_LEVELS+1];
    logic [DW_ROW-1:0]         row_p  [N_LEVELS+1][NUM_IN];
    logic signed [DW_DATA-1:0] sum_p  [N_LEVELS+1][NUM_IN];

    // Lane decode. A bubble is treated as a word with every lane disabled so
    // it flows through as all-zero and can never mark a tail.
    logic [NUM_IN-1:0]         en_in;
    logic [NUM_IN-1:0]         head_in;
    logic [NUM_IN-1:0]         tail_in;
    logic [DW_ROW-1:0]         row_in  [NUM_IN];
    logic signed [DW_DATA-1:0] data_in [NUM_IN];

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            en_in[i]   = in_valid & in[i*DW_IN + DW_IN - 1];
            row_in[i]  = en_in[i] ? in[i*DW_IN + DW_DATA +: DW_ROW] : '0;
            data_in[i] = en_in[i] ? in[i*DW_IN +: DW_DATA] : '0;
        end
    end

    // Disabled lanes are heads so the scan never carries a sum across them.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            head_in[i] = 1'b1;
            tail_in[i] = 1'b0;
            if (en_in[i]) begin
                if (i == 0)
                    head_in[i] = 1'b1;
                else
                    head_in[i] = ~en_in[(i == 0) ? 0 : i - 1] |
                                 (row_in[i] != row_in[(i == 0) ? 0 : i - 1]);
                if (i == NUM_IN - 1)
                    tail_in[i] = 1'b1;
                else
                    tail_in[i] = ~en_in[(i == NUM_IN - 1) ? i : i + 1] |
                                 (row_in[i] != row_in[(i == NUM_IN - 1) ? i : i + 1]);
            end
        end
    end

    // ---- input register ---------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p[0]  <= 1'b0;
            head_p[0] <= '0;
            tail_p[0] <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                row_p[0][i] <= '0;
                sum_p[0][i] <= '0;
            end
        end else if (adv) begin
            vld_p[0]  <= in_valid;
            head_p[0] <= head_in;
            tail_p[0] <= tail_in;
            for (int i = 0; i < NUM_IN; i++) begin
                row_p[0][i] <= row_in[i];
                sum_p[0][i] <= data_in[i];
            end
        end
    end

    // ---- scan levels: lane i pulls from lane i-2^k while not yet at a head -
    for (genvar k = 0; k < N_LEVELS; k++) begin : g_scan
        localparam int D = 1 << k;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p[k+1]  <= 1'b0;
                head_p[k+1] <= '0;
                tail_p[k+1] <= '0;
                for (int i = 0; i < NUM_IN; i++) begin
                    row_p[k+1][i] <= '0;
                    sum_p[k+1][i] <= '0;
                end
            end else if (adv) begin
                vld_p[k+1]  <= vld_p[k];
                tail_p[k+1] <= tail_p[k];
                for (int i = 0; i < NUM_IN; i++) begin
                    row_p[k+1][i] <= row_p[k][i];
                    if (i >= D && !head_p[k][i]) begin
                        sum_p[k+1][i]  <= add_wrap(sum_p[k][(i >= D) ? i - D : i],
                                                   sum_p[k][i]);
                        head_p[k+1][i] <= head_p[k][(i >= D) ? i - D : i];
                    end else begin
                        sum_p[k+1][i]  <= sum_p[k][i];
                        head_p[k+1][i] <= head_p[k][i];
                    end
                end
            end
        end
    end

    // ---- output formatting ------------------------------------------------
    logic [15:0] tail_cnt;

    assign out_valid = vld_p[LAST];

    always_comb begin
        tail_cnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            out[i*DW_OUT +: DW_OUT] = tail_p[LAST][i] ?
                {1'b1, row_p[LAST][i], sum_p[LAST][i]} : '0;
            tail_cnt = tail_cnt + 16'(tail_p[LAST][i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            seg_total <= '0;
        else if (out_valid & out_ready)
            seg_total <= seg_total + tail_cnt;
    end

endmodule

// File: tb/tb_fan_seg_reduce.sv
// ---------------------------------------------------------------------------
// tb_fan_seg_reduce
//   Directed bench for fan_seg_reduce at NUM_IN=8, DW_DATA=16, DW_ROW=4.
//   Expected output words are hand-computed and built lane by lane.
// ---------------------------------------------------------------------------
module tb_fan_seg_reduce;

    localparam int N  = 8;
    localparam int DD = 16;
    localparam int DR = 4;
    localparam int DI = DD + DR + 1;
    localparam int DO = DD + DR + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N*DI-1:0] in_w;
    logic            out_valid;
    logic            out_ready;
    logic [N*DO-1:0] out_w;
    logic [15:0]     seg_total;

    logic [N*DO-1:0] exp_w;
    logic [N*DO-1:0] held_w;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fan_seg_reduce #(
        .NUM_IN (N),
        .DW_DATA(DD),
        .DW_ROW (DR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (in_w),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out_w),
        .seg_total(seg_total)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int i, input logic en, input logic [3:0] row, input logic [15:0] d);
        in_w[i*DI +: DI] = {en, row, d};
    endtask

    task automatic set_exp(input int i, input logic [3:0] row, input logic [15:0] d);
        exp_w[i*DO +: DO] = {1'b1, row, d};
    endtask

    // Called just after a rising edge with in_w/exp_w prepared.
    task automatic run_word(input string tag, input logic [15:0] exp_total);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check({tag, "_early"}, 256'(out_valid), 256'(0));
        @(posedge clk); #1;
        check({tag, "_vld"}, 256'(out_valid), 256'(1));
        check({tag, "_out"}, 256'(out_w), 256'(exp_w));
        @(posedge clk); #1;
        check({tag, "_segtot"}, 256'(seg_total), 256'(exp_total));
        check({tag, "_drain"}, 256'(out_valid), 256'(0));
    endtask

    int rows [N] = '{0, 0, 1, 1, 1, 2, 0, 0};
    int sent;
    int rcvd;
    int accepted;
    bit held_v;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_w      = '0;
        exp_w     = '0;
        held_w    = '0;
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_seg_total", 256'(seg_total), 256'(0));
        check("rst_out", 256'(out_w), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // One run across all eight lanes: 1+2+...+8 = 36 on lane 7.
        in_w = '0; exp_w = '0;
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 4'd3, 16'(i + 1));
        set_exp(7, 4'd3, 16'd36);
        run_word("t1_full", 16'd1);

        // Rows {0,0,1,1,1,2,0,0}, data 5: runs of 2,3,1,2.
        in_w = '0; exp_w = '0;
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 4'(rows[i]), 16'd5);
        set_exp(1, 4'd0, 16'd10);
        set_exp(4, 4'd1, 16'd15);
        set_exp(5, 4'd2, 16'd5);
        set_exp(7, 4'd0, 16'd10);
        run_word("t2_rows", 16'd5);

        // Lanes 2 and 5 disabled split one row into three runs.
        in_w = '0; exp_w = '0;
        for (int i = 0; i < N; i++) set_in(i, (i != 2 && i != 5), 4'd1, 16'(i + 1));
        set_exp(1, 4'd1, 16'd3);
        set_exp(4, 4'd1, 16'd9);
        set_exp(7, 4'd1, 16'd15);
        run_word("t3_gaps", 16'd8);

        // 0x7FFF + 0x0002 wraps to 0x8001.
        in_w = '0; exp_w = '0;
        set_in(0, 1'b1, 4'd0, 16'h7FFF);
        set_in(1, 1'b1, 4'd0, 16'h0002);
        set_exp(1, 4'd0, 16'h8001);
        run_word("t4_wrap", 16'd9);

        // Six back-to-back words, consumer stalls for three cycles.
        // Word w: all lanes row w, data w+1 -> lane 7 total 8*(w+1).
        sent = 0; rcvd = 0; held_v = 1'b0;
        for (int c = 0; c < 40 && rcvd < 6; c++) begin
            out_ready = !(c >= 5 && c < 8);
            if (sent < 6) begin
                in_valid = 1'b1;
                in_w = '0;
                for (int i = 0; i < N; i++) set_in(i, 1'b1, sent[3:0], 16'(sent + 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid && held_v) check("bp_hold_out", 256'(out_w), 256'(held_w));
            if (out_valid && !out_ready) begin
                check("bp_in_ready_low", 256'(in_ready), 256'(0));
                held_w = out_w;
                held_v = 1'b1;
            end else if (out_valid) begin
                exp_w = '0;
                set_exp(7, rcvd[3:0], 16'(8 * (rcvd + 1)));
                check("bp_word", 256'(out_w), 256'(exp_w));
                rcvd++;
                held_v = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_rcvd_count", 256'(rcvd), 256'(6));
        check("bp_segtot", 256'(seg_total), 256'(15));
        repeat (4) begin @(posedge clk); #1; end
        check("bp_nodup", 256'(out_valid), 256'(0));

        // Reset with words in flight: nothing may survive it.
        in_w = '0;
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 4'd3, 16'(i + 1));
        in_valid = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        check("rst_pre_vld", 256'(out_valid), 256'(1));
        check("rst_pre_segtot", 256'(seg_total), 256'(15));
        rst_n = 1'b0;
        #1;
        check("rst_mid_vld", 256'(out_valid), 256'(0));
        check("rst_mid_segtot", 256'(seg_total), 256'(0));
        check("rst_mid_out", 256'(out_w), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("rst_no_stale", 256'(out_valid), 256'(0));
        end
        exp_w = '0;
        set_exp(7, 4'd3, 16'd36);
        run_word("rst_next", 16'd1);

        // 8200 words of eight single-lane runs -> 65600 mod 65536 = 64.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_w = '0; exp_w = '0;
        for (int i = 0; i < N; i++) begin
            set_in(i, 1'b1, 4'(i % 2), 16'(i));
            set_exp(i, 4'(i % 2), 16'(i));
        end
        accepted = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 8400 && accepted < 8200; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) accepted++;
            if (c == 10) check("seg1_word", 256'(out_w), 256'(exp_w));
            @(posedge clk); #1;
            if (accepted >= 8200) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("seg1_accepted", 256'(accepted), 256'(8200));
        repeat (6) begin @(posedge clk); #1; end
        check("seg1_wrap_total", 256'(seg_total), 256'(64));
        check("seg1_drained", 256'(out_valid), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
